// File: rtl/universal_register.sv
// universal_register: DATA_WIDTH-bit register with clear, load, increment,
// decrement and multi-bit shift/rotate executed one bit per cycle behind a
// valid/ready command handshake. Retirement of each command is signalled by
// a one-cycle done pulse; carry and zero are exported as status.
//
// Build option: define UNIVERSAL_REGISTER_SAT_EN to make INC/DEC saturate at
// all-ones / zero instead of wrapping (carry is still set at the limit).
module universal_register #(
    parameter int DATA_WIDTH = 16,
    parameter int AMT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [AMT_W-1:0]      cmd_amt,
    input  logic                  cmd_sin,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  carry,
    output logic                  zero,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_CLR = 3'd1;
    localparam logic [2:0] OP_LD  = 3'd2;
    localparam logic [2:0] OP_INC = 3'd3;
    localparam logic [2:0] OP_DEC = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] out_reg, out_next;
    logic                  carry_reg, carry_next;
    logic                  done_reg, done_next;
    logic [AMT_W-1:0]      cnt_reg, cnt_next;
    logic [2:0]            op_reg, op_next;
    logic                  sin_reg, sin_next;

    assign out       = out_reg;
    assign carry     = carry_reg;
    assign done      = done_reg;
    assign zero      = (out_reg == '0);
    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg == SHIFT);

    // State and datapath registers; reset clears everything, including mid-shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            out_reg   <= '0;
            carry_reg <= 1'b0;
            done_reg  <= 1'b0;
            cnt_reg   <= '0;
            op_reg    <= OP_NOP;
            sin_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            carry_reg <= carry_next;
            done_reg  <= done_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            sin_reg   <= sin_next;
        end
    end

    // Next-state logic: single-cycle ops retire on acceptance, shifts step once per cycle.
    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
        carry_next = carry_reg;
        done_next  = 1'b0;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        sin_next   = sin_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_NOP: begin
                            done_next = 1'b1;
                        end
                        OP_CLR: begin
                            out_next   = '0;
                            carry_next = 1'b0;
                            done_next  = 1'b1;
                        end
                        OP_LD: begin
                            out_next   = cmd_data;
                            carry_next = 1'b0;
                            done_next  = 1'b1;
                        end
                        OP_INC: begin
                            if (&out_reg) begin
`ifdef UNIVERSAL_REGISTER_SAT_EN
                                out_next = out_reg;
`else
                                out_next = '0;
`endif
                                carry_next = 1'b1;
                            end else begin
                                out_next   = out_reg + DATA_WIDTH'(1);
                                carry_next = 1'b0;
                            end
                            done_next = 1'b1;
                        end
                        OP_DEC: begin
                            if (out_reg == '0) begin
`ifdef UNIVERSAL_REGISTER_SAT_EN
                                out_next = out_reg;
`else
                                out_next = '1;
`endif
                                carry_next = 1'b1;
                            end else begin
                                out_next   = out_reg - DATA_WIDTH'(1);
                                carry_next = 1'b0;
                            end
                            done_next = 1'b1;
                        end
                        default: begin
                            // SHR/SHL/ROR: a zero count retires immediately with no change
                            if (cmd_amt == '0) begin
                                done_next = 1'b1;
                            end else begin
                                op_next    = cmd_op;
                                sin_next   = cmd_sin;
                                cnt_next   = cmd_amt;
                                state_next = SHIFT;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                case (op_reg)
                    OP_SHR: begin
                        out_next   = {sin_reg, out_reg[DATA_WIDTH-1:1]};
                        carry_next = out_reg[0];
                    end
                    OP_SHL: begin
                        out_next   = {out_reg[DATA_WIDTH-2:0], sin_reg};
                        carry_next = out_reg[DATA_WIDTH-1];
                    end
                    default: begin
                        // ROR: bit 0 wraps into the MSB
                        out_next   = {out_reg[0], out_reg[DATA_WIDTH-1:1]};
                        carry_next = out_reg[0];
                    end
                endcase
                cnt_next = cnt_reg - AMT_W'(1);
                if (cnt_reg == AMT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/universal_register.md
# universal_register

Parametrised successor to the team's basic control register: a DATA_WIDTH-bit accumulator-style register with clear, load, increment and decrement. It also has multi-bit logical shifts and a rotate, executed one bit per cycle behind a valid/ready command handshake. It sits in datapaths where a sequencer issues register micro-operations and waits on a `done` pulse. It exports carry and zero status for branch decisions.

## Interface

- `DATA_WIDTH`, default 16: register width in bits; must be ≥ 2.
- `AMT_W`, default 4: width of the shift/rotate amount field; any value ≥ 1.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `cmd_valid` input, 1 bit: a command is presented.
- `cmd_ready` output, 1 bit: the block can accept a command.
- `cmd_op` input, 3 bits: opcode.
  - 0 NOP, 1 CLR, 2 LD, 3 INC, 4 DEC.
  - 5 SHR (logical right), 6 SHL (logical left), 7 ROR (rotate right).
- `cmd_amt` input, AMT_W bits: shift/rotate count; ignored for ops 0–4.
- `cmd_sin` input, 1 bit: serial fill bit for SHR/SHL; ignored otherwise.
- `cmd_data` input, DATA_WIDTH bits: load value for LD.
- `out` output, DATA_WIDTH bits: register contents.
- `carry` output, 1 bit: registered status flag.
- `zero` output, 1 bit: combinational, equals (`out` == 0).
- `busy` output, 1 bit: high while a shift/rotate is in progress.
- `done` output, 1 bit: one-cycle pulse when a command retires.

## Operation

- FSM states: IDLE and SHIFT.
- `cmd_ready` = (state == IDLE); `busy` = (state == SHIFT).
- A command is accepted on a rising edge where `cmd_valid` && `cmd_ready`. In SHIFT, `cmd_valid` is ignored entirely and the command is not queued.
- NOP: no change to `out` or `carry`.
- CLR: `out` ← 0, `carry` ← 0.
- LD: `out` ← `cmd_data`, `carry` ← 0.
- INC: `out` ← `out` + 1 modulo 2^DATA_WIDTH; `carry` ← 1 if the old value was all-ones, else 0.
- DEC: `out` ← `out` − 1 modulo 2^DATA_WIDTH; `carry` ← 1 (borrow) if the old value was 0, else 0.
- SHR/SHL/ROR with `cmd_amt` = 0: retire like a single-cycle op, with `out` and `carry` unchanged.
- SHR/SHL/ROR with `cmd_amt` = n ≥ 1:
  - On acceptance, latch op, `cmd_sin` and n into an internal counter, and enter SHIFT. `out` is not changed on the acceptance edge.
  - On each following edge, shift `out` one bit and decrement the counter.
  - SHR: `cmd_sin` enters the MSB. SHL: `cmd_sin` enters the LSB. ROR: old bit 0 enters the MSB.
  - `carry` ← the bit shifted or rotated out on that step. After the last step, `carry` holds the last such bit.
  - When the counter reaches 0 after the n-th step, return to IDLE.
- n ≥ DATA_WIDTH is legal and executes all n steps. For SHR/SHL this leaves every bit equal to `cmd_sin`.
- Reset, asynchronous and taking effect at any time including mid-shift, forces:
  - `out` = 0, `carry` = 0, `done` = 0;
  - state = IDLE, so `busy` = 0, `cmd_ready` = 1, `zero` = 1;
  - internal counter = 0.

## Timing

- Ops 0–4 and zero-amount shifts, accepted at edge k: the new `out`/`carry` and `done` = 1 appear after edge k. `done` drops after edge k+1 unless another command retires on that edge. `cmd_ready` stays high, so back-to-back commands are accepted every cycle.
- Shift/rotate, n ≥ 1, accepted at edge k:
  - `busy` = 1 and `cmd_ready` = 0 from after edge k until after edge k+n.
  - Intermediate values are visible on `out` after edges k+1 … k+n−1.
  - The final value and `done` = 1 appear after edge k+n. `cmd_ready` returns high at the same time.
  - Total latency is n+1 cycles.
- `done` is registered and never asserts in the cycle of acceptance.

## Configuration

- Macro: `UNIVERSAL_REGISTER_SAT_EN`.
- When defined, INC and DEC saturate:
  - INC at all-ones keeps all-ones and sets `carry` = 1.
  - DEC at 0 keeps 0 and sets `carry` = 1.
- When undefined, INC and DEC wrap as described in Operation, with `carry` set on the wrap.
- Shifts, rotates and all timing are identical in both builds.

## Test plan

- Reset, then hold `rst_n` high → `out` = 0x0000, `zero` = 1, `carry` = 0, `cmd_ready` = 1, `busy` = 0, `done` = 0.
- LD 0xFFFF, then INC → without the macro, `out` = 0x0000, `carry` = 1, `zero` = 1. With `UNIVERSAL_REGISTER_SAT_EN`, `out` = 0xFFFF, `carry` = 1. `done` pulses one cycle after each accept. Also check DEC from 0x0000 → 0xFFFF with `carry` = 1 (or 0x0000 when saturating).
- LD 0x8001, then SHR amt 3 with `cmd_sin` = 1 → successive values 0xC000, 0xE000, 0xF000. `busy` is high for 3 cycles and `done` appears 4 cycles after acceptance. Final `carry` = 0.
- LD 0x1234, then ROR amt 4 → final `out` = 0x4123, `carry` = 0. Also LD 0x0001, ROR amt 1 → `out` = 0x8000, `carry` = 1.
- During a SHL amt 5, present LD 0xAAAA → it is not accepted, `out` follows the shift only, and the LD must be re-presented after `done`. Drop `rst_n` at step 2 → `out` = 0 and `busy` = 0 immediately, with no `done` pulse.
- SHR amt 0 on 0x00F0 → `out` stays 0x00F0, `carry` is unchanged, and `done` pulses after the accept edge. Also issue back-to-back INCs on consecutive cycles → each is accepted and `out` advances by 1 per cycle.
